// File: rtl/periph_bus_ic_pkg.sv
// periph_bus_ic_pkg
//   Shared types and constants for the peripheral interconnect and its
//   address decoder.
//   - ic_state_t  : transaction FSM states
//   - ERR_DATA    : read data returned on unmapped / timed-out accesses
//   - SLOT_ADDR_W : width of the slot-select field (addr[31:24])
//   - OFFSET_W    : width of the in-slot offset (addr[23:0])
//   - MAX_SLOTS   : upper bound on the number of peripheral slots
//   - idx_width() : width of a slot index for a given slot count
package periph_bus_ic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } ic_state_t;

   localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;
   localparam int          SLOT_ADDR_W = 8;
   localparam int          OFFSET_W    = 24;
   localparam int          MAX_SLOTS   = 16;

   // A single slot still needs a 1-bit index to keep vectors legal.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/periph_bus_ic_dec.sv
// periph_bus_ic_dec
//   Combinational base-table decoder. Compares an 8-bit address field with
//   every entry of a packed base table and reports whether any entry
//   matched plus the index of the lowest matching entry. Kept free of any
//   bus semantics so it can also route interrupt sources.
// Ports:
//   slot_base [N_SLOTS*8] : packed base table, entry k at [8k+7:8k]
//   addr_hi   [8]         : address field to match
//   hit                   : at least one entry matched
//   idx       [IDX_W]     : lowest matching index (0 when no hit)
module periph_bus_ic_dec
   import periph_bus_ic_pkg::*;
#(
   parameter int N_SLOTS = 8,
   parameter int IDX_W   = idx_width(N_SLOTS)
) (
   input  logic [N_SLOTS*SLOT_ADDR_W-1:0] slot_base,
   input  logic [SLOT_ADDR_W-1:0]         addr_hi,
   output logic                           hit,
   output logic [IDX_W-1:0]               idx
);

   // Scan from the top down so the lowest matching index is written last
   // and therefore wins.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int k = N_SLOTS - 1; k >= 0; k--) begin
         if (addr_hi == slot_base[k*SLOT_ADDR_W +: SLOT_ADDR_W]) begin
            hit = 1'b1;
            idx = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/periph_bus_ic.sv
// periph_bus_ic
//   Single-master peripheral interconnect. Decodes addr[31:24] against a
//   per-slot base table, issues a registered one-cycle request to the
//   selected slot, waits for that slot's ready, registers its read data and
//   returns a one-cycle ready to the master. Unmapped addresses (and, when
//   the watchdog is built in, hung slots) complete with m_err_o and
//   ERR_DATA.
// Configuration:
//   PERIPH_BUS_IC_TIMEOUT_EN : when defined, a watchdog ends WAIT after
//   TIMEOUT_CYCLES cycles with an error; otherwise WAIT holds until the
//   selected slot responds.
// Ports:
//   clk_i, resetn_i          : clock, asynchronous active-low reset
//   m_req_i/m_we_i/m_be_i    : master request, write enable, byte enables
//   m_addr_i/m_wd_i          : master byte address, write data
//   m_rd_o/m_ready_o/m_err_o : read data, completion pulse, error qualifier
//   s_req_o [N_SLOTS]        : one-hot slot request pulse
//   s_we_o/s_be_o/s_addr_o/s_wd_o : registered request fields (shared)
//   s_rd_i [N_SLOTS*32]      : packed slot read data, slot k at [32k+31:32k]
//   s_ready_i [N_SLOTS]      : per-slot completion
module periph_bus_ic
   import periph_bus_ic_pkg::*;
#(
   parameter int                               N_SLOTS        = 8,
   parameter logic [N_SLOTS*SLOT_ADDR_W-1:0]   SLOT_BASE      = 64'h0706_0504_0302_0100,
   parameter int                               TIMEOUT_CYCLES = 255
) (
   input  logic                  clk_i,
   input  logic                  resetn_i,
   input  logic                  m_req_i,
   input  logic                  m_we_i,
   input  logic [3:0]            m_be_i,
   input  logic [31:0]           m_addr_i,
   input  logic [31:0]           m_wd_i,
   output logic [31:0]           m_rd_o,
   output logic                  m_ready_o,
   output logic                  m_err_o,
   output logic [N_SLOTS-1:0]    s_req_o,
   output logic                  s_we_o,
   output logic [3:0]            s_be_o,
   output logic [31:0]           s_addr_o,
   output logic [31:0]           s_wd_o,
   input  logic [N_SLOTS*32-1:0] s_rd_i,
   input  logic [N_SLOTS-1:0]    s_ready_i
);

   localparam int IDX_W = idx_width(N_SLOTS);

   if (N_SLOTS < 1 || N_SLOTS > MAX_SLOTS) begin : g_bad_slots
      $error("periph_bus_ic: N_SLOTS out of range");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("periph_bus_ic: TIMEOUT_CYCLES out of range");
   end

   ic_state_t          state_q, state_d;
   logic [IDX_W-1:0]   sel_q;
   logic               err_q;
   logic [31:0]        rd_q;
   logic               we_q;
   logic [3:0]         be_q;
   logic [31:0]        addr_q;
   logic [31:0]        wd_q;

   logic               dec_hit;
   logic [IDX_W-1:0]   dec_idx;
   logic               slot_rdy;
   logic [31:0]        slot_rd;
   logic [N_SLOTS-1:0] sel_onehot;

   logic               accept;    // mapped request taken in IDLE
   logic               load_ok;   // selected slot answered
   logic               load_err;  // unmapped or watchdog expiry

   periph_bus_ic_dec #(
      .N_SLOTS (N_SLOTS),
      .IDX_W   (IDX_W)
   ) u_dec (
      .slot_base (SLOT_BASE),
      .addr_hi   (m_addr_i[31:OFFSET_W]),
      .hit       (dec_hit),
      .idx       (dec_idx)
   );

   // Only the latched slot's ready/data are ever looked at.
   assign slot_rdy = s_ready_i[sel_q];
   assign slot_rd  = s_rd_i[32*sel_q +: 32];

   always_comb begin
      sel_onehot        = '0;
      sel_onehot[sel_q] = 1'b1;
   end

`ifdef PERIPH_BUS_IC_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q;
   logic             wd_expired;

   // cnt_q equals the number of WAIT cycles already completed, so the
   // TIMEOUT_CYCLES-th WAIT cycle is the last one.
   assign wd_expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= '0;
      end else if (state_q == ST_WAIT && state_d == ST_WAIT) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end
`else
   logic wd_expired;
   assign wd_expired = 1'b0;
`endif

   // State register
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and datapath load strobes
   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      load_ok  = 1'b0;
      load_err = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (m_req_i) begin
               if (dec_hit) begin
                  accept  = 1'b1;
                  state_d = ST_REQ;
               end else begin
                  load_err = 1'b1;
                  state_d  = ST_RESP;
               end
            end
         end
         ST_REQ: begin
            if (slot_rdy) begin
               load_ok = 1'b1;
               state_d = ST_RESP;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A response arriving on the final watchdog cycle still wins.
            if (slot_rdy) begin
               load_ok = 1'b1;
               state_d = ST_RESP;
            end else if (wd_expired) begin
               load_err = 1'b1;
               state_d  = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Request and response registers
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         sel_q  <= '0;
         err_q  <= 1'b0;
         rd_q   <= '0;
         we_q   <= 1'b0;
         be_q   <= '0;
         addr_q <= '0;
         wd_q   <= '0;
      end else begin
         if (accept) begin
            sel_q  <= dec_idx;
            err_q  <= 1'b0;
            we_q   <= m_we_i;
            be_q   <= m_be_i;
            addr_q <= {{SLOT_ADDR_W{1'b0}}, m_addr_i[OFFSET_W-1:0]};
            wd_q   <= m_wd_i;
         end
         if (load_ok) begin
            rd_q  <= slot_rd;
            err_q <= 1'b0;
         end else if (load_err) begin
            rd_q  <= ERR_DATA;
            err_q <= 1'b1;
         end
      end
   end

   // Outputs: registers or state decodes only
   assign s_req_o   = (state_q == ST_REQ) ? sel_onehot : '0;
   assign s_we_o    = we_q;
   assign s_be_o    = be_q;
   assign s_addr_o  = addr_q;
   assign s_wd_o    = wd_q;
   assign m_ready_o = (state_q == ST_RESP);
   assign m_err_o   = (state_q == ST_RESP) & err_q;
   assign m_rd_o    = rd_q;

endmodule
